// File: rtl/img_ram_arbiter_pkg.sv
// Shared widths and state encoding for the image RAM arbiter and its selector.
package img_ram_arbiter_pkg;

  localparam int ADDR_WIDTH = 20;
  localparam int BYTE_WIDTH = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  // Index width for an n-entry selector, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/img_ram_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after rr_ptr, wrapping.
module img_ram_arbiter_rr_pick
  import img_ram_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // One spare bit so rr_ptr + offset cannot overflow before the explicit wrap.
  localparam int CW = IDX_W + 1;

  logic [CW-1:0]    cand;
  logic [IDX_W-1:0] c_idx;

  always_comb begin
    any   = 1'b0;
    idx   = '0;
    cand  = '0;
    c_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = CW'(rr_ptr) + CW'(k);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      c_idx = cand[IDX_W-1:0];
      if (req[c_idx]) begin
        any = 1'b1;
        idx = c_idx;
      end
    end
  end

endmodule

// File: rtl/img_ram_arbiter.sv
// Round-robin, burst-owning arbiter sharing one single-port image RAM between N_REQ engines.
module img_ram_arbiter
  import img_ram_arbiter_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = ADDR_WIDTH,
  parameter int DATA_W    = BYTE_WIDTH,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    ram_cen,
  output logic                    ram_wen,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_d,
  input  logic [DATA_W-1:0]       ram_q,
  output logic                    busy
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] cnt_next;

  logic             owner_req;
  logic             owner_we;
  logic             owner_last;
  logic             beat;
  logic             release_own;

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] d_hold;

  logic             rd_vld_p1;
  logic [IDX_W-1:0] rd_owner_p1;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  img_ram_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  assign owner_req  = req[owner];
  assign owner_we   = req_we[owner];
  assign owner_last = req_last[owner];
  assign beat       = (state == ARB_OWN) && owner_req;
  assign cnt_next   = beat_cnt + CNT_W'(1);

  // Ownership ends on an abandoned burst, a last beat, or the forced-release beat count.
  assign release_own = !owner_req || owner_last || (cnt_next == CNT_W'(MAX_BURST));
  assign next_ptr    = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);

  always_comb begin
    gnt = '0;
    if (beat) begin
      gnt[owner] = 1'b1;
    end
  end

  assign ram_cen  = beat;
  assign ram_wen  = beat && owner_we;
  assign ram_addr = beat ? addr_arr[owner]  : addr_hold;
  assign ram_d    = beat ? wdata_arr[owner] : d_hold;

  always_comb begin
    rvalid = '0;
    if (rd_vld_p1) begin
      rvalid[rd_owner_p1] = 1'b1;
    end
  end

  assign rdata = ram_q;
  assign busy  = (state == ARB_OWN) || rd_vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      beat_cnt    <= '0;
      addr_hold   <= '0;
      d_hold      <= '0;
      rd_vld_p1   <= 1'b0;
      rd_owner_p1 <= '0;
    end else begin
      // p1: read return follows the RAM's one-cycle latency, tagged with the beat's owner
      rd_vld_p1 <= beat && !owner_we;
      if (beat) begin
        rd_owner_p1 <= owner;
        addr_hold   <= addr_arr[owner];
        d_hold      <= wdata_arr[owner];
      end
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            owner    <= pick_idx;
            beat_cnt <= '0;
            state    <= ARB_OWN;
          end
        end
        ARB_OWN: begin
          if (owner_req) begin
            beat_cnt <= cnt_next;
          end
          if (release_own) begin
            state  <= ARB_IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_ram_arbiter.sv
// Randomised scoreboard bench for img_ram_arbiter: per-requester burst drivers, RAM model, ownership model.
module tb_img_ram_arbiter;

  localparam int N  = 3;
  localparam int AW = 20;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int LIMIT = 400;

  typedef struct {
    int         who;
    bit         we;
    int         addr;
    int         len;
    bit         has_last;
    int         delay;
    logic [7:0] dbase;
    logic [7:0] dstep;
  } burst_t;

  typedef struct {
    int         who;
    logic [7:0] d;
    int         cyc;
  } rd_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N-1:0]    req_last;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic            ram_cen;
  logic            ram_wen;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_d;
  logic [DW-1:0]   ram_q;
  logic            busy;

  int         total;
  int         bad;
  int         cyc;
  bit         abort;
  logic [N-1:0] rq_busy;
  burst_t     bq[$];
  rd_t        sbq[$];
  logic [7:0] mem [1024];
  logic [7:0] ref_mem [1024];

  img_ram_arbiter #(
    .N_REQ     (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_last  (req_last),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .ram_cen   (ram_cen),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_d     (ram_d),
    .ram_q     (ram_q),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_first(input logic [N-1:0] r, input int ptr);
    for (int o = 0; o < N; o++) begin
      if (r[(ptr + o) % N]) return (ptr + o) % N;
    end
    return -1;
  endfunction

  // Single-port RAM: command captured mid-cycle, applied at the clock edge.
  initial begin
    bit c, w;
    logic [9:0] a;
    logic [7:0] d;
    ram_q = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 7 + 3) & 255);
    forever begin
      @(negedge clk);
      c = ram_cen; w = ram_wen; a = ram_addr[9:0]; d = ram_d;
      @(posedge clk);
      if (c) begin
        if (w) mem[a] = d;
        else ram_q = mem[a];
      end
    end
  end

  task automatic add_burst(input int who, input bit we, input int addr, input int len,
                           input bit has_last, input int delay, input logic [7:0] db,
                           input logic [7:0] ds);
    burst_t b;
    b.who = who; b.we = we; b.addr = addr; b.len = len;
    b.has_last = has_last; b.delay = delay; b.dbase = db; b.dstep = ds;
    bq.push_back(b);
  endtask

  task automatic run_req(input int id);
    burst_t b;
    rd_t r;
    int idx, t, tmp;
    bit granted;
    logic [AW-1:0] a;
    logic [7:0] d;
    forever begin
      idx = -1;
      foreach (bq[j]) if (idx < 0 && bq[j].who == id) idx = j;
      if (idx < 0) begin
        @(posedge clk); #1;
      end else begin
        b = bq[idx];
        bq.delete(idx);
        rq_busy[id] = 1'b1;
        repeat (b.delay) begin @(posedge clk); #1; end
        for (int k = 0; k < b.len && !abort; k++) begin
          a = AW'(b.addr + k);
          tmp = int'(b.dbase) + int'(b.dstep) * k;
          d = tmp[7:0];
          req[id] = 1'b1;
          req_we[id] = b.we;
          req_last[id] = b.has_last && (k == b.len - 1);
          req_addr[id*AW +: AW] = a;
          req_wdata[id*DW +: DW] = d;
          granted = 0;
          t = 0;
          while (!granted && !abort && t < LIMIT) begin
            @(negedge clk);
            if (!abort && rst_n && gnt[id]) begin
              granted = 1;
              if (b.we) ref_mem[a[9:0]] = d;
              else begin
                r.who = id; r.d = ref_mem[a[9:0]]; r.cyc = cyc + 1;
                sbq.push_back(r);
              end
            end
            @(posedge clk); #1;
            t++;
          end
          if (!granted && !abort) begin
            total++; bad++;
            $display("FAIL gnt_timeout requester=%0d actual=none required=gnt within %0d cycles", id, LIMIT);
          end
        end
        req[id] = 1'b0;
        req_last[id] = 1'b0;
        @(posedge clk); #1;
        rq_busy[id] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      fork
        automatic int id = i;
        run_req(id);
      join_none
    end
  end

  // Ownership model: burst owner, beat count and round-robin pointer from the arbitration rules.
  initial begin
    bit m_active, m_rd_pend, b_beat;
    int m_owner, m_cnt, m_ptr, m_rd_who;
    logic [AW-1:0] last_a, cur_a;
    logic [DW-1:0] last_d, cur_d;
    logic [N-1:0] exp_gnt, exp_rv;
    rd_t e;
    m_active = 0; m_rd_pend = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_rd_who = 0;
    last_a = '0; last_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_active = 0; m_rd_pend = 0; m_ptr = 0; m_cnt = 0;
        last_a = '0; last_d = '0;
        sbq.delete();
      end else begin
        b_beat = m_active && req[m_owner];
        exp_gnt = '0;
        if (b_beat) exp_gnt[m_owner] = 1'b1;
        cur_a = b_beat ? req_addr[m_owner*AW +: AW] : last_a;
        cur_d = b_beat ? req_wdata[m_owner*DW +: DW] : last_d;
        exp_rv = '0;
        if (m_rd_pend) exp_rv[m_rd_who] = 1'b1;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("ram_cen", 32'(ram_cen), 32'(b_beat));
        check("ram_wen", 32'(ram_wen), 32'(b_beat && req_we[m_owner]));
        check("ram_addr", 32'(ram_addr), 32'(cur_a));
        check("ram_d", 32'(ram_d), 32'(cur_d));
        check("rvalid", 32'(rvalid), 32'(exp_rv));
        check("busy", 32'(busy), 32'(m_active || m_rd_pend));
        if (rvalid != '0) begin
          if (sbq.size() == 0) begin
            check("rd_unexpected", 32'(rvalid), 32'h0);
          end else begin
            e = sbq.pop_front();
            check("rd_who", 32'(rvalid), 32'(1 << e.who));
            check("rdata", 32'(rdata), 32'(e.d));
            check("rd_latency", 32'(cyc), 32'(e.cyc));
          end
        end
        last_a = cur_a;
        last_d = cur_d;
        m_rd_pend = b_beat && !req_we[m_owner];
        m_rd_who = m_owner;
        if (m_active) begin
          if (!req[m_owner]) begin
            m_active = 0;
            m_ptr = (m_owner + 1) % N;
          end else begin
            m_cnt++;
            if (req_last[m_owner] || m_cnt == MB) begin
              m_active = 0;
              m_ptr = (m_owner + 1) % N;
            end
          end
        end else if (req != '0) begin
          m_owner = rr_first(req, m_ptr);
          m_active = 1;
          m_cnt = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while ((bq.size() != 0 || rq_busy != '0) && t < 6000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    if (t >= 6000) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=pending required=idle within 6000 cycles");
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_rvalid"}, 32'(rvalid), 32'h0);
    check({tag, "_cen"}, 32'(ram_cen), 32'h0);
    check({tag, "_wen"}, 32'(ram_wen), 32'h0);
    check({tag, "_addr"}, 32'(ram_addr), 32'h0);
    check({tag, "_d"}, 32'(ram_d), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int t;
    total = 0; bad = 0; abort = 0; rq_busy = '0;
    rst_n = 1'b0; req = '0; req_we = '0; req_last = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'((i * 7 + 3) & 255);
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");

    // Requesters 0 and 2 at reset release, then both again: 0, 2, 0, 2.
    add_burst(0, 1, 'h200, 2, 1, 0, 8'h21, 8'h01);
    add_burst(2, 1, 'h280, 2, 1, 0, 8'h41, 8'h01);
    add_burst(0, 0, 'h280, 2, 1, 0, 8'h00, 8'h00);
    add_burst(2, 0, 'h200, 2, 1, 0, 8'h00, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle();

    // Requester 1 writes AA/BB/CC at 0x36..0x38, then reads them back.
    add_burst(1, 1, 'h36, 3, 1, 0, 8'hAA, 8'h11);
    wait_idle();
    check("mem_36", 32'(mem['h36]), 32'hAA);
    check("mem_37", 32'(mem['h37]), 32'hBB);
    check("mem_38", 32'(mem['h38]), 32'hCC);
    add_burst(1, 0, 'h36, 3, 1, 0, 8'h00, 8'h00);
    add_burst(0, 0, 'h10, 2, 1, 2, 8'h00, 8'h00);
    add_burst(2, 0, 'h20, 2, 1, 2, 8'h00, 8'h00);
    wait_idle();

    // Preload 0x10..0x13 at 0x100, read burst of 4 by requester 2.
    add_burst(1, 1, 'h100, 4, 1, 0, 8'h10, 8'h01);
    wait_idle();
    add_burst(2, 0, 'h100, 4, 1, 0, 8'h00, 8'h00);
    wait_idle();

    // 20-beat burst forced to release at 16 beats while requester 1 waits.
    add_burst(0, 1, 'h300, 20, 1, 0, 8'h05, 8'h03);
    add_burst(1, 0, 'h100, 3, 1, 3, 8'h00, 8'h00);
    wait_idle();
    add_burst(0, 0, 'h300, 20, 1, 0, 8'h00, 8'h00);
    wait_idle();

    // Owner abandons mid-burst with requester 2 pending.
    add_burst(0, 1, 'h380, 6, 0, 0, 8'h77, 8'h05);
    add_burst(2, 0, 'h380, 4, 1, 2, 8'h00, 8'h00);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      add_burst($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 990),
                $urandom_range(1, 20), $urandom_range(0, 4) != 0, $urandom_range(0, 3),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    wait_idle();

    // Reset asserted during a granted read beat.
    add_burst(2, 0, 'h100, 4, 1, 0, 8'h00, 8'h00);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(gnt[2] && !ram_wen) && t < 200);
    check("rst_read_seen", 32'(gnt[2] && !ram_wen), 32'h1);
    #1;
    rst_n = 1'b0;
    abort = 1;
    bq.delete();
    #1;
    check_quiet("midrst");
    t = 0;
    while (rq_busy != '0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk); #1;
    abort = 0;
    rst_n = 1'b1;
    add_burst(2, 0, 'h36, 2, 1, 0, 8'h00, 8'h00);
    add_burst(0, 0, 'h100, 2, 1, 0, 8'h00, 8'h00);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (gnt == '0 && t < 50);
    check("first_after_rst", 32'(gnt), 32'h1);
    wait_idle();
    check("scoreboard_empty", 32'(sbq.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
